// File: rtl/snake_score_bcd.sv
// ---------------------------------------------------------------------------
// snake_score_bcd
//   Score keeper for the snake game, one stage upstream of the
//   seven-segment scan driver. It counts food events as a two-digit packed
//   BCD score, tracks the best score of the session, and sequences the game
//   phases IDLE -> PLAY -> OVER. In OVER the display word blinks between the
//   final score and the best score.
//
// Parameters
//   STEP          BCD points added per food event (1..9)
//   MAX_SCORE     saturation ceiling, valid packed BCD
//   BLINK_CYCLES  clk cycles per display phase while in OVER (>= 2)
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   start/restart request, rising edge acted on
//   eat        in   snake head on food, rising edge = one event
//   game_over  in   collision flag (level)
//   q          out  packed BCD display word, [7:4] tens, [3:0] units
//   score      out  current score, packed BCD
//   best       out  best score since reset, packed BCD
//   new_best   out  high in OVER when the finished game set a new best
//   state      out  phase: 00 IDLE, 01 PLAY, 10 OVER
// ---------------------------------------------------------------------------
module snake_score_bcd #(
    parameter int unsigned STEP         = 1,
    parameter logic [7:0]  MAX_SCORE    = 8'h99,
    parameter int unsigned BLINK_CYCLES = 25_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       eat,
    input  logic       game_over,
    output logic [7:0] q,
    output logic [7:0] score,
    output logic [7:0] best,
    output logic       new_best,
    output logic [1:0] state
);

    localparam int unsigned CW = (BLINK_CYCLES > 2) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_CYCLES - 1);
    localparam logic [4:0]    STEP_W   = 5'(STEP);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_PLAY = 2'b01;
    localparam logic [1:0] ST_OVER = 2'b10;

    logic [1:0]    state_q, state_d;
    logic [7:0]    score_q, score_d;
    logic [7:0]    best_q, best_d;
    logic          new_best_q, new_best_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;
    logic          eat_prev_q;
    logic          start_prev_q;

    logic          eat_rise;
    logic          start_rise;
    logic [7:0]    score_inc;

    // Packed-BCD add of STEP with saturation at MAX_SCORE. A tens overflow
    // past 9 also saturates, so the result is always valid BCD.
    function automatic logic [7:0] bcd_add(input logic [7:0] v);
        logic [4:0] units;
        logic [4:0] tens;
        logic       carry;
        logic [7:0] res;
        units = {1'b0, v[3:0]} + STEP_W;
        carry = (units > 5'd9);
        if (carry) begin
            units = units - 5'd10;
        end
        tens = {1'b0, v[7:4]} + {4'b0000, carry};
        res  = {tens[3:0], units[3:0]};
        if ((tens > 5'd9) || (res > MAX_SCORE)) begin
            res = MAX_SCORE;
        end
        return res;
    endfunction

    assign eat_rise   = eat & ~eat_prev_q;
    assign start_rise = start & ~start_prev_q;

    // Same-cycle eat is folded in before the game-over compare so the best
    // score sees the final value.
    assign score_inc  = eat_rise ? bcd_add(score_q) : score_q;

    always_comb begin
        state_d    = state_q;
        score_d    = score_q;
        best_d     = best_q;
        new_best_d = new_best_q;
        cnt_d      = cnt_q;
        phase_d    = phase_q;

        case (state_q)
            ST_IDLE: begin
                if (start_rise) begin
                    state_d    = ST_PLAY;
                    score_d    = '0;
                    new_best_d = 1'b0;
                end
            end

            ST_PLAY: begin
                score_d = score_inc;
                if (game_over) begin
                    state_d = ST_OVER;
                    cnt_d   = '0;
                    phase_d = 1'b0;
                    if (score_inc > best_q) begin
                        best_d     = score_inc;
                        new_best_d = 1'b1;
                    end else begin
                        new_best_d = 1'b0;
                    end
                end
            end

            ST_OVER: begin
                if (start_rise) begin
                    state_d    = ST_PLAY;
                    score_d    = '0;
                    new_best_d = 1'b0;
                    cnt_d      = '0;
                    phase_d    = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    phase_d = ~phase_q;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            score_q      <= '0;
            best_q       <= '0;
            new_best_q   <= 1'b0;
            cnt_q        <= '0;
            phase_q      <= 1'b0;
            eat_prev_q   <= 1'b0;
            start_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            score_q      <= score_d;
            best_q       <= best_d;
            new_best_q   <= new_best_d;
            cnt_q        <= cnt_d;
            phase_q      <= phase_d;
            eat_prev_q   <= eat;
            start_prev_q <= start;
        end
    end

    // Display word is decoded purely from registers.
    always_comb begin
        case (state_q)
            ST_IDLE: q = best_q;
            ST_PLAY: q = score_q;
            ST_OVER: q = phase_q ? best_q : score_q;
            default: q = '0;
        endcase
    end

    assign score    = score_q;
    assign best     = best_q;
    assign new_best = new_best_q;
    assign state    = state_q;

endmodule

// File: tb/tb_snake_score_bcd.sv
module tb_snake_score_bcd;

    // Two instances share stimulus: index 0 uses STEP=1, index 1 uses STEP=5.
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       eat = 1'b0;
    logic       game_over = 1'b0;
    logic [7:0] q_w     [2];
    logic [7:0] score_w [2];
    logic [7:0] best_w  [2];
    logic       nb_w    [2];
    logic [1:0] st_w    [2];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    snake_score_bcd #(.STEP(1), .MAX_SCORE(8'h99), .BLINK_CYCLES(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .eat(eat), .game_over(game_over),
        .q(q_w[0]), .score(score_w[0]), .best(best_w[0]), .new_best(nb_w[0]), .state(st_w[0])
    );

    snake_score_bcd #(.STEP(5), .MAX_SCORE(8'h99), .BLINK_CYCLES(4)) dut5 (
        .clk(clk), .rst_n(rst_n), .start(start), .eat(eat), .game_over(game_over),
        .q(q_w[1]), .score(score_w[1]), .best(best_w[1]), .new_best(nb_w[1]), .state(st_w[1])
    );

    // Reference model: decimal scores, phase from elapsed OVER cycles.
    typedef struct packed {
        int   st;   // 0 idle, 1 play, 2 over
        int   sc;   // decimal score
        int   bs;   // decimal best
        logic nb;
        int   oc;   // cycles spent in OVER
        logic pe;
        logic ps;
    } mdl_t;

    mdl_t m [2];

    function automatic mdl_t mdl_step(mdl_t cur, int stp, logic e, logic s, logic g);
        mdl_t n;
        n = cur;
        if (cur.st == 0) begin
            if (s && !cur.ps) begin n.st = 1; n.sc = 0; n.nb = 1'b0; end
        end else if (cur.st == 1) begin
            if (e && !cur.pe) n.sc = (cur.sc + stp > 99) ? 99 : cur.sc + stp;
            if (g) begin
                n.st = 2; n.oc = 0;
                if (n.sc > cur.bs) begin n.bs = n.sc; n.nb = 1'b1; end
                else n.nb = 1'b0;
            end
        end else begin
            if (s && !cur.ps) begin n.st = 1; n.sc = 0; n.nb = 1'b0; n.oc = 0; end
            else n.oc = cur.oc + 1;
        end
        n.pe = e;
        n.ps = s;
        return n;
    endfunction

    function automatic logic [7:0] bcd(int v);
        return 8'(((v / 10) << 4) + (v % 10));
    endfunction

    function automatic logic [7:0] mdl_q(mdl_t x);
        if (x.st == 0) return bcd(x.bs);
        if (x.st == 1) return bcd(x.sc);
        return (((x.oc / 4) % 2) == 1) ? bcd(x.bs) : bcd(x.sc);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) m[i] <= '0;
            else        m[i] <= mdl_step(m[i], (i == 0) ? 1 : 5, eat, start, game_over);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Inputs change on the falling edge; outputs are read there too.
    task automatic cyc(input logic e, input logic s, input logic g);
        eat = e; start = s; game_over = g;
        @(negedge clk);
    endtask

    task automatic do_eat(input int n);
        for (int k = 0; k < n; k++) begin
            cyc(1'b1, 1'b0, 1'b0);
            cyc(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        eat = 1'b0; start = 1'b0; game_over = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if ({q_w[i], score_w[i], best_w[i], nb_w[i], st_w[i]} !== 27'd0) begin
                n_bad++;
                $display("FAIL reset[%0d]: got q=%h score=%h best=%h nb=%b st=%b, exp all zero",
                         i, q_w[i], score_w[i], best_w[i], nb_w[i], st_w[i]);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_count();
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 12; k++) begin
            cyc(1'b1, 1'b0, 1'b0);
            cyc(1'b1, 1'b0, 1'b0);
            cyc(1'b1, 1'b0, 1'b0);
            cyc(1'b0, 1'b0, 1'b0);
        end
        n_cmp++;
        if (score_w[0] !== 8'h12 || q_w[0] !== 8'h12 || st_w[0] !== 2'b01) begin
            n_bad++;
            $display("FAIL count_step1: got score=%h q=%h st=%b, exp 12 12 01", score_w[0], q_w[0], st_w[0]);
        end
        n_cmp++;
        if (score_w[1] !== 8'h60 || q_w[1] !== 8'h60) begin
            n_bad++;
            $display("FAIL count_step5: got score=%h q=%h, exp 60 60", score_w[1], q_w[1]);
        end
    endtask

    task automatic test_saturate();
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        do_eat(9);
        n_cmp++;
        if (score_w[0] !== 8'h09) begin
            n_bad++; $display("FAIL bcd_09: got %h exp 09", score_w[0]);
        end
        do_eat(1);
        n_cmp++;
        if (score_w[0] !== 8'h10 || score_w[1] !== 8'h50) begin
            n_bad++; $display("FAIL bcd_carry: got %h/%h exp 10/50", score_w[0], score_w[1]);
        end
        do_eat(88);
        n_cmp++;
        if (score_w[0] !== 8'h98 || score_w[1] !== 8'h99) begin
            n_bad++; $display("FAIL bcd_98: got %h/%h exp 98/99", score_w[0], score_w[1]);
        end
        for (int k = 0; k < 3; k++) begin
            do_eat(1);
            n_cmp++;
            if (score_w[0] !== 8'h99 || score_w[1] !== 8'h99) begin
                n_bad++; $display("FAIL saturate[%0d]: got %h/%h exp 99/99", k, score_w[0], score_w[1]);
            end
        end
    endtask

    task automatic test_best_blink();
        logic [7:0] exp0, exp1;
        do_reset();
        cyc(1'b0, 1'b1, 1'b0);
        do_eat(15);
        cyc(1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (st_w[0] !== 2'b10 || best_w[0] !== 8'h15 || nb_w[0] !== 1'b1 ||
            best_w[1] !== 8'h75 || nb_w[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL game1_best: got st=%b best=%h nb=%b best5=%h nb5=%b, exp 10 15 1 75 1",
                     st_w[0], best_w[0], nb_w[0], best_w[1], nb_w[1]);
        end
        cyc(1'b0, 1'b1, 1'b0);
        do_eat(7);
        cyc(1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (best_w[0] !== 8'h15 || nb_w[0] !== 1'b0 || score_w[0] !== 8'h07 ||
            best_w[1] !== 8'h75 || nb_w[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL game2_best: got best=%h nb=%b score=%h best5=%h nb5=%b, exp 15 0 07 75 0",
                     best_w[0], nb_w[0], score_w[0], best_w[1], nb_w[1]);
        end
        for (int k = 0; k < 16; k++) begin
            exp0 = (((k / 4) % 2) == 1) ? 8'h15 : 8'h07;
            exp1 = (((k / 4) % 2) == 1) ? 8'h75 : 8'h35;
            n_cmp++;
            if (q_w[0] !== exp0 || q_w[1] !== exp1) begin
                n_bad++;
                $display("FAIL blink[%0d]: got %h/%h exp %h/%h", k, q_w[0], q_w[1], exp0, exp1);
            end
            cyc(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_same_cycle();
        cyc(1'b0, 1'b1, 1'b0);
        do_eat(20);
        cyc(1'b1, 1'b0, 1'b1);
        n_cmp++;
        if (score_w[0] !== 8'h21 || best_w[0] !== 8'h21 || st_w[0] !== 2'b10 || nb_w[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL eat_and_over: got score=%h best=%h st=%b nb=%b, exp 21 21 10 1",
                     score_w[0], best_w[0], st_w[0], nb_w[0]);
        end
        n_cmp++;
        if (score_w[1] !== 8'h99 || best_w[1] !== 8'h99 || nb_w[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL eat_and_over5: got score=%h best=%h nb=%b, exp 99 99 1",
                     score_w[1], best_w[1], nb_w[1]);
        end
        cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_async_reset();
        do_reset();
        cyc(1'b0, 1'b1, 1'b0);
        do_eat(33);
        n_cmp++;
        if (score_w[0] !== 8'h33) begin
            n_bad++; $display("FAIL pre_reset: got %h exp 33", score_w[0]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if ({q_w[i], score_w[i], best_w[i], st_w[i]} !== 26'd0) begin
                n_bad++;
                $display("FAIL async_reset[%0d]: got q=%h score=%h best=%h st=%b, exp all zero",
                         i, q_w[i], score_w[i], best_w[i], st_w[i]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_restart();
        cyc(1'b0, 1'b1, 1'b0);
        do_eat(2);
        n_cmp++;
        if (score_w[1] !== 8'h10 || score_w[0] !== 8'h02) begin
            n_bad++; $display("FAIL step5_carry: got %h/%h exp 02/10", score_w[0], score_w[1]);
        end
        cyc(1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 10; k++) cyc(1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (st_w[0] !== 2'b01 || score_w[0] !== 8'h00 || st_w[1] !== 2'b01) begin
            n_bad++; $display("FAIL start_held: got st=%b score=%h st5=%b, exp 01 00 01",
                              st_w[0], score_w[0], st_w[1]);
        end
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (st_w[1] !== 2'b01 || score_w[1] !== 8'h05) begin
            n_bad++; $display("FAIL restart_once: got st=%b score=%h, exp 01 05", st_w[1], score_w[1]);
        end
        do_eat(18);
        n_cmp++;
        if (score_w[1] !== 8'h95) begin
            n_bad++; $display("FAIL step5_95: got %h exp 95", score_w[1]);
        end
        do_eat(1);
        n_cmp++;
        if (score_w[1] !== 8'h99 || score_w[0] !== 8'h20) begin
            n_bad++; $display("FAIL step5_sat: got %h/%h exp 20/99", score_w[0], score_w[1]);
        end
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        n_cmp++;
        if (st_w[0] !== 2'b01 || score_w[0] !== 8'h00) begin
            n_bad++; $display("FAIL reenter_play: got st=%b score=%h, exp 01 00", st_w[0], score_w[0]);
        end
        cyc(1'b0, 1'b1, 1'b1);
        n_cmp++;
        if (st_w[0] !== 2'b10 || score_w[0] !== 8'h00 || best_w[0] !== 8'h20 || nb_w[0] !== 1'b0 ||
            best_w[1] !== 8'h99) begin
            n_bad++;
            $display("FAIL immediate_over: got st=%b score=%h best=%h nb=%b best5=%h, exp 10 00 20 0 99",
                     st_w[0], score_w[0], best_w[0], nb_w[0], best_w[1]);
        end
        cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if (q_w[i] !== mdl_q(m[i]) || score_w[i] !== bcd(m[i].sc) || best_w[i] !== bcd(m[i].bs) ||
                    nb_w[i] !== m[i].nb || st_w[i] !== 2'(m[i].st)) begin
                    n_bad++;
                    $display("FAIL random[%0d/%0d]: got q=%h sc=%h bs=%h nb=%b st=%b exp q=%h sc=%h bs=%h nb=%b st=%0d",
                             k, i, q_w[i], score_w[i], best_w[i], nb_w[i], st_w[i],
                             mdl_q(m[i]), bcd(m[i].sc), bcd(m[i].bs), m[i].nb, m[i].st);
                end
            end
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 15) == 0));
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_count();
        test_saturate();
        test_best_blink();
        test_same_cycle();
        test_async_reset();
        test_restart();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
